instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port imemReq  output  1  instruction-memory read request.
REQ-006 SHALL have port imemAddr  output  XLEN  read address; equals pc.
REQ-007 SHALL have port imemRdata  input  32  instruction word, valid when imemAck=1.
REQ-008 SHALL have port imemAck  input  1  memory completion strobe.
REQ-009 SHALL have port instr  output  32  held instruction word.
REQ-010 SHALL have port op  output  7  instr[6:0], feeds the main decoder opcode input.
REQ-011 SHALL have port instrValid  output  1  instr/op/pc are valid for the current instruction.
REQ-012 SHALL have port instrDone  input  1  core finished executing the held instruction.
REQ-013 SHALL have port pcSrc  input  1  1 = take pcTarget, 0 = sequential pc+4; sampled with instrDone.
REQ-014 SHALL have port pcTarget  input  XLEN  branch target address.
REQ-015 SHALL have port pc  output  XLEN  address of the held/fetching instruction.
REQ-016 SHALL have port retCount  output  32  count of retired instructions.
REQ-017 SHALL have port misalign  output  1  misaligned-next-PC fault flag.

Function
REQ-018 SHALL implement states FETCH, HOLD, FAULT; state after reset is FETCH.
REQ-019 FETCH: imemReq=1 and imemAddr=pc every cycle until imemAck=1; on ack, instr<=imemRdata, next state HOLD.
REQ-020 HOLD: imemReq=0, instrValid=1; instr, op, pc stable until instrDone=1.
REQ-021 HOLD with instrDone=1: pc<=pcSrc ? pcTarget : pc+4, retCount<=retCount+1, instrValid drops next cycle, next state FETCH.
REQ-022 Minimum latency: ack in first FETCH cycle -> instrValid=1 on the following cycle; fetch-to-fetch loop of 2 cycles when instrDone is immediate.
REQ-023 pc+4 and retCount SHALL wrap modulo 2^XLEN and 2^32 respectively, no flag.
REQ-024 imemAck outside FETCH and instrDone outside HOLD SHALL be ignored (no state, pc, or counter change).
REQ-025 imemRdata SHALL be captured only in the ack cycle; later changes do not alter instr.
REQ-026 op SHALL be combinationally instr[6:0] at all times.

Reset
REQ-027 On a rising edge with rst_n=0: state=FETCH, pc=RESET_PC, instr=0, instrValid=0, retCount=0, misalign=0; imemReq=1 from the first cycle after reset release.
REQ-028 Reset asserted mid-FETCH or mid-HOLD SHALL abandon the in-flight fetch; an imemAck in the reset cycle is discarded.

Configuration
REQ-029 Macro MISALIGN_CHECK_EN defined: if the selected next pc has bits[1:0]!=0, pc takes that value, state goes to FAULT, misalign=1, imemReq=0, instrValid=0, retCount still increments; FAULT held until reset.
REQ-030 MISALIGN_CHECK_EN undefined: next pc bits[1:0] forced to 00, FAULT unreachable, misalign tied 0.

Structure
REQ-031 Shared package riscv_pkg SHALL hold the fetch state enum, opcode constants (LW 0000011, SW 0100011, RTYPE 0110011, BEQ 1100011), and the default RESET_PC.
REQ-032 Next-PC adder/mux SHALL be a sub-module pc_next (inputs pc, pcSrc, pcTarget; output next pc).

Verification
REQ-033 Reset, imemAck=1 first cycle with imemRdata=32'h0000_2083 -> next cycle instrValid=1, op=0000011, pc=0, imemReq=0.
REQ-034 instrDone=1, pcSrc=0 at pc=0 -> FETCH with imemAddr=4, retCount=1; ack delayed 3 cycles -> imemReq held high 4 cycles, addr stable at 4.
REQ-035 instrDone=1, pcSrc=1, pcTarget=32'h0000_0100 -> imemAddr=32'h100; pc=32'hFFFF_FFFC with pcSrc=0 -> imemAddr wraps to 0.
REQ-036 Spurious imemAck in HOLD and instrDone in FETCH -> instr, pc, retCount unchanged.
REQ-037 rst_n=0 during HOLD with retCount=5 -> next cycle instrValid=0, pc=RESET_PC, retCount=0.
REQ-038 With MISALIGN_CHECK_EN, pcTarget=32'h102, pcSrc=1 -> misalign=1, imemReq=0 indefinitely; without it -> imemAddr=32'h100.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: fetch FSM states, base opcodes, default reset vector.
package riscv_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } fetchState_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: branch target or sequential pc+4 (wraps modulo 2^XLEN).
module pc_next #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            pcSrc,
    input  logic [XLEN-1:0] pcTarget,
    output logic [XLEN-1:0] nextPc
);

    always_comb begin
        nextPc = pcSrc ? pcTarget : pc + XLEN'(4);
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: FETCH/HOLD handshake with imem and core, retire counter.
// Build option MISALIGN_CHECK_EN: trap misaligned next-PC into a sticky FAULT state.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic [31:0]     imemRdata,
    input  logic            imemAck,
    output logic [31:0]     instr,
    output logic [6:0]      op,
    output logic            instrValid,
    input  logic            instrDone,
    input  logic            pcSrc,
    input  logic [XLEN-1:0] pcTarget,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     retCount,
    output logic            misalign
);

    fetchState_t     state;
    logic [XLEN-1:0] nextPcRaw;
    logic [XLEN-1:0] nextPc;
    logic            nextMisaligned;

    pc_next #(
        .XLEN(XLEN)
    ) uPcNext (
        .pc       (pc),
        .pcSrc    (pcSrc),
        .pcTarget (pcTarget),
        .nextPc   (nextPcRaw)
    );

`ifdef MISALIGN_CHECK_EN
    always_comb begin
        nextPc         = nextPcRaw;
        nextMisaligned = |nextPcRaw[1:0];
    end

    // FAULT is only entered from HOLD and cleared by reset, so the state alone is the flag.
    assign misalign = (state == FAULT);
`else
    always_comb begin
        nextPc         = nextPcRaw & ~XLEN'(3);
        nextMisaligned = 1'b0;
    end

    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            instr    <= '0;
            retCount <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imemAck) begin
                        instr <= imemRdata;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (instrDone) begin
                        pc       <= nextPc;
                        retCount <= retCount + 32'd1;
                        state    <= nextMisaligned ? FAULT : FETCH;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    assign imemReq    = (state == FETCH);
    assign instrValid = (state == HOLD);
    assign imemAddr   = pc;
    assign op         = instr[6:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected events, a negedge monitor pops and checks.
module tb_instr_fetch;

    localparam int K_REQ   = 0;
    localparam int K_VALID = 1;
    localparam int K_FAULT = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] instrExp;
        logic [31:0] ret;
        int          cycles;
        bit          chkInstr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        imemAck;
    logic [31:0] instr;
    logic [6:0]  op;
    logic        instrValid;
    logic        instrDone;
    logic        pcSrc;
    logic [31:0] pcTarget;
    logic [31:0] pc;
    logic [31:0] retCount;
    logic        misalign;

    exp_t expQ[$];
    int   tests = 0;
    int   fails = 0;
    bit   endReq = 0;
    bit   monDone = 0;

    instr_fetch #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemRdata  (imemRdata),
        .imemAck    (imemAck),
        .instr      (instr),
        .op         (op),
        .instrValid (instrValid),
        .instrDone  (instrDone),
        .pcSrc      (pcSrc),
        .pcTarget   (pcTarget),
        .pc         (pc),
        .retCount   (retCount),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, expv, $time);
        end
    endtask

    task automatic pushReq(input logic [31:0] addr, input logic [31:0] ret, input int cycles, input bit chkInstr);
        exp_t e;
        e.kind = K_REQ; e.addr = addr; e.instrExp = '0; e.ret = ret; e.cycles = cycles; e.chkInstr = chkInstr;
        expQ.push_back(e);
    endtask

    task automatic pushValid(input logic [31:0] ins, input logic [31:0] addr, input logic [31:0] ret);
        exp_t e;
        e.kind = K_VALID; e.addr = addr; e.instrExp = ins; e.ret = ret; e.cycles = 0; e.chkInstr = 1'b0;
        expQ.push_back(e);
    endtask

    task automatic pushFault(input logic [31:0] addr, input logic [31:0] ret);
        exp_t e;
        e.kind = K_FAULT; e.addr = addr; e.instrExp = '0; e.ret = ret; e.cycles = 0; e.chkInstr = 1'b0;
        expQ.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: event detection on output edges plus per-cycle stability checks.
    bit          prevReq = 1'b0;
    bit          prevValid = 1'b0;
    bit          prevMis = 1'b0;
    int          reqRun = 0;
    int          curCycles = 0;
    logic [31:0] curAddr = '0;
    logic [31:0] curInstr = '0;
    logic [31:0] curPc = '0;
    logic [31:0] curRet = '0;

    always @(negedge clk) begin
        exp_t e;
        if (imemReq === 1'b1 && !prevReq) begin
            reqRun = 0;
            if (expQ.size() == 0) begin
                check("req_queue_size", 32'(expQ.size()), 32'd1);
            end else begin
                e = expQ.pop_front();
                check("req_kind", 32'(e.kind), 32'(K_REQ));
                check("req_addr", imemAddr, e.addr);
                check("req_retCount", retCount, e.ret);
                check("req_instrValid", {31'd0, instrValid}, 32'd0);
                check("req_misalign", {31'd0, misalign}, 32'd0);
                if (e.chkInstr) check("reset_instr", instr, 32'd0);
                curAddr   = e.addr;
                curCycles = e.cycles;
            end
        end
        if (imemReq === 1'b0 && prevReq && curCycles != 0)
            check("req_run_length", 32'(reqRun), 32'(curCycles));
        if (imemReq === 1'b1) begin
            reqRun++;
            check("fetch_addr_stable", imemAddr, curAddr);
        end

        if (instrValid === 1'b1 && !prevValid) begin
            if (expQ.size() == 0) begin
                check("valid_queue_size", 32'(expQ.size()), 32'd1);
            end else begin
                e = expQ.pop_front();
                check("valid_kind", 32'(e.kind), 32'(K_VALID));
                curInstr = e.instrExp;
                curPc    = e.addr;
                curRet   = e.ret;
            end
        end
        if (instrValid === 1'b1) begin
            check("hold_instr", instr, curInstr);
            check("hold_op", {25'd0, op}, {25'd0, curInstr[6:0]});
            check("hold_pc", pc, curPc);
            check("hold_retCount", retCount, curRet);
            check("hold_imemReq", {31'd0, imemReq}, 32'd0);
        end

        if (misalign === 1'b1 && !prevMis) begin
            if (expQ.size() == 0) begin
                check("fault_queue_size", 32'(expQ.size()), 32'd1);
            end else begin
                e = expQ.pop_front();
                check("fault_kind", 32'(e.kind), 32'(K_FAULT));
                check("fault_retCount", retCount, e.ret);
                curPc = e.addr;
            end
        end
        if (misalign === 1'b1) begin
            check("fault_pc", pc, curPc);
            check("fault_imemReq", {31'd0, imemReq}, 32'd0);
            check("fault_instrValid", {31'd0, instrValid}, 32'd0);
        end

        prevReq   = (imemReq === 1'b1);
        prevValid = (instrValid === 1'b1);
        prevMis   = (misalign === 1'b1);

        if (endReq && !monDone) begin
            check("queue_left", 32'(expQ.size()), 32'd0);
            monDone = 1'b1;
        end
    end

    initial begin
        rst_n = 1'b0; imemAck = 1'b0; imemRdata = '0;
        instrDone = 1'b0; pcSrc = 1'b0; pcTarget = '0;
        pushReq(32'h0, 32'd0, 0, 1'b1);
        repeat (3) tick();

        // First fetch acked in the first cycle after reset release
        rst_n = 1'b1; imemAck = 1'b1; imemRdata = 32'h0000_2083;
        pushValid(32'h0000_2083, 32'h0, 32'd0);
        tick();
        // Spurious ack and changing rdata while holding
        imemRdata = 32'hDEAD_BEEF; imemAck = 1'b1;
        tick();
        imemAck = 1'b0;
        tick();

        // Sequential retire, then a 4-cycle fetch with a spurious instrDone
        instrDone = 1'b1; pcSrc = 1'b0;
        pushReq(32'h4, 32'd1, 4, 1'b0);
        tick();
        instrDone = 1'b1; pcSrc = 1'b1; pcTarget = 32'h0000_0040;
        tick();
        instrDone = 1'b0;
        tick();
        tick();
        imemAck = 1'b1; imemRdata = 32'h0000_0013;
        pushValid(32'h0000_0013, 32'h4, 32'd1);
        tick();
        imemAck = 1'b0;

        // Taken branch to 0x100, minimum-latency loop
        instrDone = 1'b1; pcSrc = 1'b1; pcTarget = 32'h0000_0100;
        pushReq(32'h100, 32'd2, 1, 1'b0);
        tick();
        instrDone = 1'b0; imemAck = 1'b1; imemRdata = 32'h0020_8033;
        pushValid(32'h0020_8033, 32'h100, 32'd2);
        tick();
        imemAck = 1'b0;

        instrDone = 1'b1; pcSrc = 1'b1; pcTarget = 32'hFFFF_FFFC;
        pushReq(32'hFFFF_FFFC, 32'd3, 1, 1'b0);
        tick();
        instrDone = 1'b0; imemAck = 1'b1; imemRdata = 32'h0011_2023;
        pushValid(32'h0011_2023, 32'hFFFF_FFFC, 32'd3);
        tick();
        imemAck = 1'b0;

        // pc+4 wraps to 0
        instrDone = 1'b1; pcSrc = 1'b0;
        pushReq(32'h0, 32'd4, 1, 1'b0);
        tick();
        instrDone = 1'b0; imemAck = 1'b1; imemRdata = 32'h0020_8663;
        pushValid(32'h0020_8663, 32'h0, 32'd4);
        tick();
        imemAck = 1'b0;

        instrDone = 1'b1; pcSrc = 1'b0;
        pushReq(32'h4, 32'd5, 1, 1'b0);
        tick();
        instrDone = 1'b0; imemAck = 1'b1; imemRdata = 32'h0000_2083;
        pushValid(32'h0000_2083, 32'h4, 32'd5);
        tick();
        imemAck = 1'b0;
        tick();

        // Reset during HOLD with retCount=5, ack in the reset cycle discarded
        rst_n = 1'b0; imemAck = 1'b1;
        pushReq(32'h0, 32'd0, 0, 1'b1);
        tick();
        rst_n = 1'b1; imemAck = 1'b0;
        tick();

        // Misaligned branch target
        imemAck = 1'b1; imemRdata = 32'h0000_0013;
        pushValid(32'h0000_0013, 32'h0, 32'd0);
        tick();
        imemAck = 1'b0;
        instrDone = 1'b1; pcSrc = 1'b1; pcTarget = 32'h0000_0102;
`ifdef MISALIGN_CHECK_EN
        pushFault(32'h0000_0102, 32'd1);
        tick();
        instrDone = 1'b0; imemAck = 1'b1;
        repeat (5) tick();
        imemAck = 1'b0;
`else
        pushReq(32'h100, 32'd1, 1, 1'b0);
        tick();
        instrDone = 1'b0; imemAck = 1'b1; imemRdata = 32'h0000_0013;
        pushValid(32'h0000_0013, 32'h100, 32'd1);
        tick();
        imemAck = 1'b0;
        tick();
`endif

        endReq = 1'b1;
        for (int i = 0; i < 10 && !monDone; i++) tick();
        if (!monDone) begin
            $display("FAIL monitor_timeout: got no completion expected completion within 10 cycles");
            $fatal(1, "monitor did not complete");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
